// File: rtl/mw_pipe_reg.sv
// M->W pipeline register with W-stage load extension; optional retire counter via MW_RETIRE_CNT_EN.
// Latency: one cycle M->W; DR_W and PC8_W are combinational from the W registers.
// Backpressure: en=0 holds every register; flush loads a bubble and overrides hold.
module mw_pipe_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        flush,
    input  logic [31:0] IR_M,
    input  logic [31:0] PC_M,
    input  logic [31:0] AO_M,
    input  logic [31:0] DM_M,
    input  logic [31:0] CP0_M,
    input  logic        BD_M,
    output logic [31:0] IR_W,
    output logic [31:0] PC_W,
    output logic [31:0] PC8_W,
    output logic [31:0] AO_W,
    output logic [31:0] DR_W,
    output logic [31:0] CP0_W,
    output logic        BD_W,
    output logic        valid_W,
    output logic [31:0] retire_cnt
);

    typedef struct packed {
        logic [31:0] ir;
        logic [31:0] pc;
        logic [31:0] ao;
        logic [31:0] dm;
        logic [31:0] cp0;
        logic        bd;
        logic        vld;
    } mw_stage_t;

    localparam mw_stage_t BUBBLE = '{ir: 32'h0, pc: RESET_PC, ao: 32'h0, dm: 32'h0,
                                     cp0: 32'h0, bd: 1'b0, vld: 1'b0};

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;

    mw_stage_t stage_d;
    mw_stage_t stage_q;

    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = BUBBLE;
        end else if (en) begin
            stage_d.ir  = IR_M;
            stage_d.pc  = PC_M;
            stage_d.ao  = AO_M;
            stage_d.dm  = DM_M;
            stage_d.cp0 = CP0_M;
            stage_d.bd  = BD_M;
            stage_d.vld = (IR_M != 32'h0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stage_q <= BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

`ifdef MW_RETIRE_CNT_EN
    logic [31:0] retire_cnt_d;
    logic [31:0] retire_cnt_q;

    // Counts what enters W, so nops and bubbles never increment.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (en && !flush && (IR_M != 32'h0)) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            retire_cnt_q <= 32'h0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;
`else
    assign retire_cnt = 32'h0;
`endif

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Little-endian lane select; AO_W[0] is ignored for halfwords.
    always_comb begin
        ld_byte = stage_q.dm[8*stage_q.ao[1:0] +: 8];
        ld_half = stage_q.dm[16*stage_q.ao[1] +: 16];
        case (stage_q.ir[31:26])
            OP_LB:   DR_W = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  DR_W = {24'h0, ld_byte};
            OP_LH:   DR_W = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  DR_W = {16'h0, ld_half};
            OP_LW:   DR_W = stage_q.dm;
            default: DR_W = stage_q.dm;
        endcase
    end

    assign IR_W    = stage_q.ir;
    assign PC_W    = stage_q.pc;
    assign PC8_W   = stage_q.pc + 32'd8;
    assign AO_W    = stage_q.ao;
    assign CP0_W   = stage_q.cp0;
    assign BD_W    = stage_q.bd;
    assign valid_W = stage_q.vld;

endmodule

// File: tb/tb_mw_pipe_reg.sv
// Directed self-checking bench for mw_pipe_reg; expectations are hand-computed constants.
module tb_mw_pipe_reg;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        en = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] IR_M = 32'h0;
    logic [31:0] PC_M = 32'h0;
    logic [31:0] AO_M = 32'h0;
    logic [31:0] DM_M = 32'h0;
    logic [31:0] CP0_M = 32'h0;
    logic        BD_M = 1'b0;
    logic [31:0] IR_W, PC_W, PC8_W, AO_W, DR_W, CP0_W, retire_cnt;
    logic        BD_W, valid_W;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_cnt = 32'h0;
    logic [31:0] exp_ret;

    localparam logic [31:0] I_LB  = 32'h8022_0004;
    localparam logic [31:0] I_LBU = 32'h9022_0004;
    localparam logic [31:0] I_LH  = 32'h8422_0004;
    localparam logic [31:0] I_LHU = 32'h9422_0004;
    localparam logic [31:0] I_LW  = 32'h8C22_0004;
    localparam logic [31:0] I_ADD = 32'h0022_1821;

    mw_pipe_reg dut (
        .clk(clk), .reset(reset), .en(en), .flush(flush),
        .IR_M(IR_M), .PC_M(PC_M), .AO_M(AO_M), .DM_M(DM_M), .CP0_M(CP0_M), .BD_M(BD_M),
        .IR_W(IR_W), .PC_W(PC_W), .PC8_W(PC8_W), .AO_W(AO_W), .DR_W(DR_W),
        .CP0_W(CP0_W), .BD_W(BD_W), .valid_W(valid_W), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expected_retire();
`ifdef MW_RETIRE_CNT_EN
        exp_ret = exp_cnt;
`else
        exp_ret = 32'h0;
`endif
    endtask

    task automatic drive(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] ao,
                         input logic [31:0] dm, input logic [31:0] cp0, input logic bd);
        IR_M = ir; PC_M = pc; AO_M = ao; DM_M = dm; CP0_M = cp0; BD_M = bd;
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b1; flush = 1'b0;
        drive($urandom, $urandom, $urandom, $urandom, $urandom, 1'b1);
        step();
        drive($urandom, $urandom, $urandom, $urandom, $urandom, 1'b1);
        step();
        exp_cnt = 32'h0;
        expected_retire();
        checks++; if (IR_W !== 32'h0) begin errors++; $display("FAIL reset_ir: got %h want %h", IR_W, 32'h0); end
        checks++; if (PC_W !== 32'h3000) begin errors++; $display("FAIL reset_pc: got %h want %h", PC_W, 32'h3000); end
        checks++; if (PC8_W !== 32'h3008) begin errors++; $display("FAIL reset_pc8: got %h want %h", PC8_W, 32'h3008); end
        checks++; if (valid_W !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_W); end
        checks++; if ({AO_W, CP0_W, DR_W, 31'h0, BD_W} !== 128'h0) begin errors++;
            $display("FAIL reset_data: got ao=%h cp0=%h dr=%h bd=%b want zeros", AO_W, CP0_W, DR_W, BD_W); end
        checks++; if (retire_cnt !== exp_ret) begin errors++; $display("FAIL reset_retire: got %h want %h", retire_cnt, exp_ret); end
    endtask

    task automatic test_lb_capture();
        reset = 1'b1; en = 1'b1; flush = 1'b0;
        drive(I_LB, 32'h3010, 32'h2, 32'h1280_3456, 32'hCAFE_0001, 1'b1);
        step();
        exp_cnt = exp_cnt + 32'd1;
        expected_retire();
        checks++; if (DR_W !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_dr: got %h want %h", DR_W, 32'hFFFF_FF80); end
        checks++; if (PC8_W !== 32'h3018) begin errors++; $display("FAIL lb_pc8: got %h want %h", PC8_W, 32'h3018); end
        checks++; if (valid_W !== 1'b1) begin errors++; $display("FAIL lb_valid: got %b want 1", valid_W); end
        checks++; if ({IR_W, PC_W, AO_W, CP0_W, BD_W} !== {I_LB, 32'h3010, 32'h2, 32'hCAFE_0001, 1'b1}) begin errors++;
            $display("FAIL lb_regs: got ir=%h pc=%h ao=%h cp0=%h bd=%b", IR_W, PC_W, AO_W, CP0_W, BD_W); end
        checks++; if (retire_cnt !== exp_ret) begin errors++; $display("FAIL lb_retire: got %h want %h", retire_cnt, exp_ret); end
    endtask

    task automatic test_loads();
        logic [31:0] ir_tab [6]  = '{I_LHU, I_LH, I_LW, I_LBU, I_LB, I_ADD};
        logic [31:0] ao_tab [6]  = '{32'h3, 32'h3, 32'h3, 32'h1, 32'h1, 32'h0};
        logic [31:0] exp_tab [6] = '{32'h0000_8001, 32'hFFFF_8001, 32'h8001_7FFF,
                                     32'h0000_007F, 32'h0000_007F, 32'h8001_7FFF};
        for (int i = 0; i < 6; i++) begin
            drive(ir_tab[i], 32'h3020 + 32'(4*i), ao_tab[i], 32'h8001_7FFF, 32'h0, 1'b0);
            step();
            exp_cnt = exp_cnt + 32'd1;
            checks++; if (DR_W !== exp_tab[i]) begin errors++;
                $display("FAIL load_dr[%0d]: got %h want %h", i, DR_W, exp_tab[i]); end
        end
        drive(I_LB, 32'h3040, 32'h0, 32'h0000_0080, 32'h0, 1'b0);
        step();
        exp_cnt = exp_cnt + 32'd1;
        checks++; if (DR_W !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_lane0: got %h want %h", DR_W, 32'hFFFF_FF80); end
        drive(I_LH, 32'h3044, 32'h1, 32'h1234_8765, 32'h0, 1'b0);
        step();
        exp_cnt = exp_cnt + 32'd1;
        expected_retire();
        checks++; if (DR_W !== 32'hFFFF_8765) begin errors++; $display("FAIL lh_ao0_ignored: got %h want %h", DR_W, 32'hFFFF_8765); end
        checks++; if (retire_cnt !== exp_ret) begin errors++; $display("FAIL loads_retire: got %h want %h", retire_cnt, exp_ret); end
    endtask

    task automatic test_hold_flush();
        drive(I_LW, 32'h3100, 32'h0000_0040, 32'hDEAD_BEEF, 32'h1111_2222, 1'b1);
        step();
        exp_cnt = exp_cnt + 32'd1;
        expected_retire();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(I_ADD, 32'h4000, 32'h5, 32'h0, 32'h0, 1'b0);
            step();
            checks++; if ({IR_W, PC_W, PC8_W, AO_W, DR_W, CP0_W, BD_W, valid_W} !==
                          {I_LW, 32'h3100, 32'h3108, 32'h40, 32'hDEAD_BEEF, 32'h1111_2222, 1'b1, 1'b1}) begin errors++;
                $display("FAIL hold[%0d]: got ir=%h pc=%h ao=%h dr=%h cp0=%h bd=%b v=%b", i, IR_W, PC_W, AO_W, DR_W, CP0_W, BD_W, valid_W); end
            checks++; if (retire_cnt !== exp_ret) begin errors++;
                $display("FAIL hold_retire[%0d]: got %h want %h", i, retire_cnt, exp_ret); end
        end
        flush = 1'b1;
        step();
        checks++; if ({IR_W, PC_W, PC8_W, AO_W, DR_W, CP0_W, BD_W, valid_W} !==
                      {32'h0, 32'h3000, 32'h3008, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0}) begin errors++;
            $display("FAIL flush_bubble: got ir=%h pc=%h ao=%h dr=%h cp0=%h bd=%b v=%b", IR_W, PC_W, AO_W, DR_W, CP0_W, BD_W, valid_W); end
        checks++; if (retire_cnt !== exp_ret) begin errors++; $display("FAIL flush_retire: got %h want %h", retire_cnt, exp_ret); end
        flush = 1'b0; en = 1'b1;
        drive(I_ADD, 32'h3200, 32'h7, 32'h0, 32'h0, 1'b0);
        step();
        exp_cnt = exp_cnt + 32'd1;
        expected_retire();
        checks++; if ({IR_W, PC_W, valid_W} !== {I_ADD, 32'h3200, 1'b1}) begin errors++;
            $display("FAIL flush_resume: got ir=%h pc=%h v=%b want ir=%h pc=%h v=1", IR_W, PC_W, valid_W, I_ADD, 32'h3200); end
        checks++; if (retire_cnt !== exp_ret) begin errors++; $display("FAIL resume_retire: got %h want %h", retire_cnt, exp_ret); end
    endtask

    task automatic test_nop_wrap();
        drive(32'h0, 32'h3300, 32'h9, 32'h0, 32'h0, 1'b0);
        step();
        expected_retire();
        checks++; if (valid_W !== 1'b0) begin errors++; $display("FAIL nop_valid: got %b want 0", valid_W); end
        checks++; if (PC_W !== 32'h3300) begin errors++; $display("FAIL nop_pc: got %h want %h", PC_W, 32'h3300); end
        checks++; if (retire_cnt !== exp_ret) begin errors++; $display("FAIL nop_retire: got %h want %h", retire_cnt, exp_ret); end
`ifdef MW_RETIRE_CNT_EN
        force dut.retire_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_cnt_q;
        exp_cnt = 32'h0;
`endif
        drive(I_ADD, 32'h3304, 32'h0, 32'h0, 32'h0, 1'b0);
        step();
        expected_retire();
        checks++; if (retire_cnt !== exp_ret) begin errors++; $display("FAIL wrap_retire: got %h want %h", retire_cnt, exp_ret); end
    endtask

    task automatic test_midstream_reset();
        drive(I_LW, 32'h3400, 32'h4, 32'h5555_AAAA, 32'h1, 1'b1);
        step();
        drive(I_LB, 32'h3404, 32'h1, 32'h0000_FF00, 32'h2, 1'b0);
        step();
        checks++; if ({IR_W, DR_W} !== {I_LB, 32'hFFFF_FFFF}) begin errors++;
            $display("FAIL pre_reset: got ir=%h dr=%h want ir=%h dr=%h", IR_W, DR_W, I_LB, 32'hFFFF_FFFF); end
        reset = 1'b0; en = 1'b1;
        drive(I_ADD, 32'h3408, 32'h3, 32'h3, 32'h3, 1'b1);
        step();
        checks++; if ({IR_W, PC_W, PC8_W, AO_W, DR_W, CP0_W, BD_W, valid_W} !==
                      {32'h0, 32'h3000, 32'h3008, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0}) begin errors++;
            $display("FAIL midreset_bubble: got ir=%h pc=%h ao=%h dr=%h cp0=%h bd=%b v=%b", IR_W, PC_W, AO_W, DR_W, CP0_W, BD_W, valid_W); end
        checks++; if (retire_cnt !== 32'h0) begin errors++; $display("FAIL midreset_retire: got %h want 0", retire_cnt); end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lb_capture();
        test_loads();
        test_hold_flush();
        test_nop_wrap();
        test_midstream_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
